// File: rtl/darksimv_xtor_pkg.sv
// rtl/darksimv_xtor_pkg.sv - shared types and constants for the darksimv beat sequencer
//
// Contents:
//   XT_DW / XT_AW / XT_GW : field widths of the queue entry structs
//   DROP_MAX              : saturation value of the dropped-capture counter
//   seq_state_e           : sequencer FSM states
//   stim_entry_t          : one stimulus beat {idata, datai, gap}
//   mon_entry_t           : one captured core cycle
//   sat_inc16             : saturating 16-bit increment
package darksimv_xtor_pkg;

    localparam int XT_DW = 32;
    localparam int XT_AW = 32;
    localparam int XT_GW = 4;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [XT_DW-1:0] idata;
        logic [XT_DW-1:0] datai;
        logic [XT_GW-1:0] gap;
    } stim_entry_t;

    typedef struct packed {
        logic [XT_DW-1:0] idata;
        logic [XT_AW-1:0] iaddr;
        logic [XT_DW-1:0] datai;
        logic [XT_DW-1:0] datao;
        logic [XT_AW-1:0] daddr;
        logic [2:0]       dlen;
        logic             drd;
        logic             dwr;
    } mon_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == DROP_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/darksimv_sync_fifo.sv
// rtl/darksimv_sync_fifo.sv - synchronous FIFO with flush and occupancy level
//
// Ports:
//   clk, resn          : clock, synchronous active-low reset
//   flush              : empties the FIFO; wins over same-cycle push/pop
//   push, push_data    : write request (taken when not full, or full with a same-cycle pop)
//   pop, pop_data      : read request; pop_data is the head entry
//   full, empty, level : occupancy status
import darksimv_xtor_pkg::*;

module darksimv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   resn,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        full     = (level == (PW+1)'(DEPTH));
        empty    = (wr_ptr_q == rd_ptr_q);
        do_pop   = pop && !empty && !flush;
        // A pop in the same cycle frees the slot the push needs.
        do_push  = push && (!full || do_pop) && !flush;
        pop_data = mem_q[rd_ptr_q[PW-1:0]];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resn && do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/darksimv_beat_sequencer.sv
// rtl/darksimv_beat_sequencer.sv - streams queued beats into the darksimv core and captures its cycles
//
// Ports:
//   CLK, RESN, FLUSH                 : clock, sync active-low reset, queue/FSM flush pulse
//   S_VALID/S_READY/S_IDATA/S_DATAI/S_GAP : stimulus beat stream in
//   HLT, IDATA, DATAI                : registered drive to the core
//   IADDR, DADDR, DATAO, DLEN, DRD, DWR   : core outputs sampled on each run cycle
//   M_VALID/M_READY/M_ENTRY          : captured-cycle stream out
//   S_LEVEL, M_LEVEL                 : queue occupancies
//   M_OVF, M_DROPS                   : sticky overflow flag and saturating drop count
// DW/AW/GW must match the package entry widths.
import darksimv_xtor_pkg::*;

module darksimv_beat_sequencer #(
    parameter int DW     = XT_DW,
    parameter int AW     = XT_AW,
    parameter int SDEPTH = 8,
    parameter int MDEPTH = 8,
    parameter int GW     = XT_GW
) (
    input  logic                    CLK,
    input  logic                    RESN,
    input  logic                    FLUSH,
    input  logic                    S_VALID,
    output logic                    S_READY,
    input  logic [DW-1:0]           S_IDATA,
    input  logic [DW-1:0]           S_DATAI,
    input  logic [GW-1:0]           S_GAP,
    output logic                    HLT,
    output logic [DW-1:0]           IDATA,
    output logic [DW-1:0]           DATAI,
    input  logic [AW-1:0]           IADDR,
    input  logic [AW-1:0]           DADDR,
    input  logic [DW-1:0]           DATAO,
    input  logic [2:0]              DLEN,
    input  logic                    DRD,
    input  logic                    DWR,
    output logic                    M_VALID,
    input  logic                    M_READY,
    output mon_entry_t              M_ENTRY,
    output logic [$clog2(SDEPTH):0] S_LEVEL,
    output logic [$clog2(MDEPTH):0] M_LEVEL,
    output logic                    M_OVF,
    output logic [15:0]             M_DROPS
);

    stim_entry_t s_wdata, s_head;
    logic        s_full, s_empty, s_push, s_pop;
    mon_entry_t  m_wdata;
    logic        m_full, m_empty, m_pop;
    logic        capture, drop, take_next;

    seq_state_e  state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic        hlt_q, hlt_d;
    logic [DW-1:0] idata_q, idata_d;
    logic [DW-1:0] datai_q, datai_d;
    logic        m_ovf_q, m_ovf_d;
    logic [15:0] m_drops_q, m_drops_d;

    darksimv_sync_fifo #(
        .WIDTH($bits(stim_entry_t)),
        .DEPTH(SDEPTH)
    ) u_stim_fifo (
        .clk      (CLK),
        .resn     (RESN),
        .flush    (FLUSH),
        .push     (s_push),
        .push_data(s_wdata),
        .pop      (s_pop),
        .pop_data (s_head),
        .full     (s_full),
        .empty    (s_empty),
        .level    (S_LEVEL)
    );

    darksimv_sync_fifo #(
        .WIDTH($bits(mon_entry_t)),
        .DEPTH(MDEPTH)
    ) u_mon_fifo (
        .clk      (CLK),
        .resn     (RESN),
        .flush    (FLUSH),
        .push     (capture),
        .push_data(m_wdata),
        .pop      (m_pop),
        .pop_data (M_ENTRY),
        .full     (m_full),
        .empty    (m_empty),
        .level    (M_LEVEL)
    );

    // Stream handshakes and capture path.
    always_comb begin
        // Held low during reset; otherwise reflects pre-pop occupancy only.
        S_READY = RESN && !s_full;
        s_push  = S_VALID && S_READY;
        s_wdata = '{idata: S_IDATA, datai: S_DATAI, gap: S_GAP};
        M_VALID = !m_empty;
        m_pop   = M_READY && !m_empty;
        m_wdata = '{idata: idata_q, iaddr: IADDR, datai: datai_q, datao: DATAO,
                    daddr: DADDR, dlen: DLEN, drd: DRD, dwr: DWR};
        capture = (state_q == RUN) && !FLUSH;
        // A same-cycle pop leaves room, so only a full queue without a pop drops.
        drop    = capture && m_full && !m_pop;
    end

    // Sequencer next-state.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        hlt_d     = hlt_q;
        idata_d   = idata_q;
        datai_d   = datai_q;
        s_pop     = 1'b0;
        take_next = 1'b0;

        case (state_q)
            IDLE: take_next = 1'b1;
            RUN: begin
                if (gap_q != '0) begin
                    state_d = GAP;
                    hlt_d   = 1'b1;
                end else begin
                    take_next = 1'b1;
                end
            end
            GAP: begin
                // Counter holds the remaining halt cycles including this one.
                if (gap_q <= GW'(1)) take_next = 1'b1;
                else                 gap_d     = gap_q - GW'(1);
            end
            default: begin
                state_d = IDLE;
                hlt_d   = 1'b1;
            end
        endcase

        if (take_next) begin
            if (!s_empty) begin
                s_pop   = 1'b1;
                state_d = RUN;
                hlt_d   = 1'b0;
                idata_d = s_head.idata;
                datai_d = s_head.datai;
                gap_d   = s_head.gap;
            end else begin
                state_d = IDLE;
                hlt_d   = 1'b1;
                gap_d   = '0;
            end
        end

        m_ovf_d   = m_ovf_q | drop;
        m_drops_d = drop ? sat_inc16(m_drops_q) : m_drops_q;

        if (FLUSH) begin
            state_d   = IDLE;
            hlt_d     = 1'b1;
            gap_d     = '0;
            s_pop     = 1'b0;
            m_ovf_d   = 1'b0;
            m_drops_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESN) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            hlt_q     <= 1'b1;
            idata_q   <= '0;
            datai_q   <= '0;
            m_ovf_q   <= 1'b0;
            m_drops_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            hlt_q     <= hlt_d;
            idata_q   <= idata_d;
            datai_q   <= datai_d;
            m_ovf_q   <= m_ovf_d;
            m_drops_q <= m_drops_d;
        end
    end

    assign HLT     = hlt_q;
    assign IDATA   = idata_q;
    assign DATAI   = datai_q;
    assign M_OVF   = m_ovf_q;
    assign M_DROPS = m_drops_q;

endmodule
